// File: rtl/n64_state_uart_pkg.sv
// n64_pkg: shared constants, serializer state type and baud divisor helper for n64_state_uart
package n64_pkg;
  localparam int FRAME_BYTES = 5;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/n64_state_uart_if.sv
// n64_state_uart_if: controller snapshot in, UART line and status out
interface n64_state_uart_if;
  logic [31:0] ctrl_state;
  logic ctrl_clk;
  logic tx;
  logic busy;
  logic frame_done;
  logic overrun;
  modport master (output ctrl_state, ctrl_clk, input tx, busy, frame_done, overrun);
  modport slave (input ctrl_state, ctrl_clk, output tx, busy, frame_done, overrun);
endinterface

// File: rtl/n64_state_uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer; ready is also high in the last stop-bit cycle so bytes chain with no gap
module uart_tx_byte
  import n64_pkg::*;
#(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  uart_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic tx_q, last;
  assign last = cnt_q == CW'(DIV - 1);
  assign ready_o = state_q == IDLE || (state_q == STOP && last);
  assign tx_o = tx_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
    end else begin
      cnt_q <= (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
      if (start_i && ready_o) begin
        state_q <= START;
        sh_q <= data_i;
        tx_q <= 1'b0;
      end else if (last) begin
        case (state_q)
          START: begin
            state_q <= DATA;
            bit_q <= '0;
            tx_q <= sh_q[0];
            sh_q <= sh_q >> 1;
          end
          DATA: begin
            state_q <= (bit_q == 3'd7) ? STOP : DATA;
            bit_q <= bit_q + 3'd1;
            tx_q <= (bit_q == 3'd7) | sh_q[0];
            sh_q <= sh_q >> 1;
          end
          STOP: state_q <= IDLE;
          default: ;
        endcase
      end
    end
endmodule

// File: rtl/n64_state_uart.sv
// n64_state_uart: serializes each N64 controller snapshot as a 5-byte 8N1 frame (sync + state MSB first).
// Optional N64_STATE_UART_CHANGE_ONLY_EN: only snapshots differing from the last sent one are framed.
module n64_state_uart
  import n64_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD = 115200,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input logic clk,
  input logic rst,
  n64_state_uart_if.slave bus
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  logic [2:0] sync_q, byte_idx_q;
  logic [31:0] snap_q, frame_q;
  logic pend_q, busy_q, done_q, ovr_q;
  logic edge_det, accept, take, next_byte, fin, ser_ready, ser_start, ser_tx;
  logic [7:0] ser_data;
  assign edge_det = sync_q[1] & ~sync_q[2];
`ifdef N64_STATE_UART_CHANGE_ONLY_EN
  logic [31:0] last_q;
  logic last_v_q;
  assign accept = edge_det && (!last_v_q || bus.ctrl_state != last_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_q <= '0;
      last_v_q <= 1'b0;
    end else if (take) begin
      last_q <= snap_q;
      last_v_q <= 1'b1;
    end
`else
  assign accept = edge_det;
`endif
  // The sync byte is constant, so a frame can start in the same cycle the snapshot is loaded
  assign take = !busy_q && pend_q;
  assign next_byte = busy_q && ser_ready && byte_idx_q != 3'(FRAME_BYTES - 1);
  assign fin = busy_q && ser_ready && byte_idx_q == 3'(FRAME_BYTES - 1);
  assign ser_start = take || next_byte;
  assign ser_data = take ? SYNC_BYTE : frame_q[31:24];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      snap_q <= '0;
      frame_q <= '0;
      byte_idx_q <= '0;
      pend_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.ctrl_clk};
      if (accept) snap_q <= bus.ctrl_state;
      pend_q <= accept || (pend_q && !take);
      ovr_q <= accept && pend_q && !take;
      done_q <= fin;
      if (take) begin
        busy_q <= 1'b1;
        byte_idx_q <= '0;
        frame_q <= snap_q;
      end else if (next_byte) begin
        byte_idx_q <= byte_idx_q + 3'd1;
        frame_q <= {frame_q[23:0], 8'h00};
      end else if (fin) busy_q <= 1'b0;
    end
  uart_tx_byte #(.DIV(DIV)) u_tx (
    .clk(clk),
    .rst(rst),
    .start_i(ser_start),
    .data_i(ser_data),
    .ready_o(ser_ready),
    .tx_o(ser_tx)
  );
  assign bus.tx = ser_tx;
  assign bus.busy = busy_q;
  assign bus.frame_done = done_q;
  assign bus.overrun = ovr_q;
endmodule
